// File: rtl/shared_buffer_ctrl.sv
// Front-end for the shared-memory multi-list linked list: owns the payload RAM,
// serialises push/pop to the list and round-robins dequeue requests across lists.
module shared_buffer_ctrl #(
  parameter int unsigned NUM_ELEMS = 4,
  parameter int unsigned NUM_LISTS = 2,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PTR_WIDTH = $clog2(NUM_ELEMS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enq_valid,
  input  logic [NUM_LISTS-1:0] enq_list,
  input  logic [WIDTH-1:0]     enq_data,
  output logic                 enq_ready,
  input  logic [NUM_LISTS-1:0] deq_req,
  output logic                 deq_valid,
  input  logic                 deq_ready,
  output logic [WIDTH-1:0]     deq_data,
  output logic [NUM_LISTS-1:0] deq_list,
  output logic                 enq_err,
  output logic [NUM_LISTS-1:0] ll_push,
  output logic [NUM_LISTS-1:0] ll_pop,
  input  logic                 ll_full,
  input  logic [NUM_LISTS-1:0] ll_empty,
  input  logic [PTR_WIDTH-1:0] ll_free_ptr,
  input  logic [PTR_WIDTH-1:0] ll_popped_head
);

  localparam int unsigned LIST_W = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1;

  typedef enum logic {
    PRIO_PUSH = 1'b0,
    PRIO_POP  = 1'b1
  } prio_t;

  prio_t                prio_q, prio_d;
  logic [LIST_W-1:0]    rr_ptr, rr_next, grant_idx;
  logic [NUM_LISTS-1:0] eligible, grant;
  logic                 grant_found;
  logic                 out_free, cand_push, cand_pop, do_push, do_pop, enq_onehot;
  logic [WIDTH-1:0]     ram [NUM_ELEMS];

  assign eligible   = deq_req & ~ll_empty;
  assign out_free   = ~deq_valid | deq_ready;
  assign cand_push  = enq_valid & ~ll_full;
  assign cand_pop   = (|eligible) & out_free;
  assign enq_onehot = (enq_list != '0) && ((enq_list & (enq_list - 1'b1)) == '0);

  // Only one list operation per cycle; prio decides contested cycles only.
  assign do_push = rst_n & cand_push & (~cand_pop | (prio_q == PRIO_PUSH));
  assign do_pop  = rst_n & cand_pop & (~cand_push | (prio_q == PRIO_POP));

  assign enq_ready = do_push;
  assign ll_push   = (do_push && enq_onehot) ? enq_list : '0;
  assign ll_pop    = do_pop ? grant : '0;

  always_comb begin : rr_arb
    int unsigned idx;
    idx         = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int unsigned i = 0; i < NUM_LISTS; i++) begin
      idx = (32'(rr_ptr) + i) % NUM_LISTS;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = LIST_W'(idx);
      end
    end
  end

  assign rr_next = (grant_idx == LIST_W'(NUM_LISTS - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    prio_d = prio_q;
    if (cand_push && cand_pop) begin
      prio_d = (prio_q == PRIO_PUSH) ? PRIO_POP : PRIO_PUSH;
    end
  end

  always_ff @(posedge clk) begin
    if (|ll_push) begin
      ram[ll_free_ptr] <= enq_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deq_valid <= 1'b0;
      deq_data  <= '0;
      deq_list  <= '0;
      enq_err   <= 1'b0;
      rr_ptr    <= '0;
      prio_q    <= PRIO_PUSH;
    end else begin
      prio_q <= prio_d;
      if (enq_ready && !enq_onehot) begin
        enq_err <= 1'b1;
      end
      // The list presents the popped head combinationally, so the payload is
      // captured at the same edge the pop strobe takes effect.
      if (do_pop) begin
        deq_valid <= 1'b1;
        deq_data  <= ram[ll_popped_head];
        deq_list  <= grant;
        rr_ptr    <= rr_next;
      end else if (deq_ready) begin
        deq_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shared_buffer_ctrl.sv
// Scoreboard bench for shared_buffer_ctrl: behavioural linked-list model drives the
// ll_* inputs; a per-list data queue model predicts arbitration, grants and payloads.
module tb_shared_buffer_ctrl;

  localparam int NE = 4;
  localparam int NL = 2;
  localparam int W  = 8;
  localparam int PW = 2;

  logic          clk, rst_n;
  logic          enq_valid, enq_ready, deq_valid, deq_ready, enq_err, ll_full;
  logic [NL-1:0] enq_list, deq_req, deq_list, ll_push, ll_pop, ll_empty;
  logic [W-1:0]  enq_data, deq_data;
  logic [PW-1:0] ll_free_ptr, ll_popped_head;

  shared_buffer_ctrl #(
    .NUM_ELEMS(NE),
    .NUM_LISTS(NL),
    .WIDTH    (W),
    .PTR_WIDTH(PW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enq_valid     (enq_valid),
    .enq_list      (enq_list),
    .enq_data      (enq_data),
    .enq_ready     (enq_ready),
    .deq_req       (deq_req),
    .deq_valid     (deq_valid),
    .deq_ready     (deq_ready),
    .deq_data      (deq_data),
    .deq_list      (deq_list),
    .enq_err       (enq_err),
    .ll_push       (ll_push),
    .ll_pop        (ll_pop),
    .ll_full       (ll_full),
    .ll_empty      (ll_empty),
    .ll_free_ptr   (ll_free_ptr),
    .ll_popped_head(ll_popped_head)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Linked-list model: slot stack for free slots, FIFO of slots per list.
  int            lst [NL][NE];
  int            cnt [NL];
  int            free_stk [NE];
  int            free_cnt;
  logic [PW-1:0] head_slot [NL];
  logic [NL-1:0] pend_push, pend_pop;

  task automatic ll_refresh();
    ll_full     = (free_cnt == 0);
    ll_free_ptr = (free_cnt > 0) ? PW'(free_stk[free_cnt-1]) : '0;
    for (int l = 0; l < NL; l++) begin
      ll_empty[l]  = (cnt[l] == 0);
      head_slot[l] = (cnt[l] > 0) ? PW'(lst[l][0]) : '0;
    end
  endtask

  task automatic ll_reset();
    free_cnt = NE;
    for (int s = 0; s < NE; s++) free_stk[s] = NE - 1 - s;
    for (int l = 0; l < NL; l++) cnt[l] = 0;
    pend_push = '0;
    pend_pop  = '0;
    ll_refresh();
  endtask

  task automatic ll_apply();
    for (int l = 0; l < NL; l++) begin
      if (pend_pop[l] && cnt[l] > 0) begin
        free_stk[free_cnt] = lst[l][0];
        free_cnt++;
        for (int k = 0; k < NE - 1; k++) lst[l][k] = lst[l][k+1];
        cnt[l]--;
      end
    end
    for (int l = 0; l < NL; l++) begin
      if (pend_push[l] && free_cnt > 0) begin
        free_cnt--;
        lst[l][cnt[l]] = free_stk[free_cnt];
        cnt[l]++;
      end
    end
    pend_push = '0;
    pend_pop  = '0;
    ll_refresh();
  endtask

  always_comb begin
    ll_popped_head = '0;
    for (int l = 0; l < NL; l++) begin
      if (ll_pop[l]) ll_popped_head = head_slot[l];
    end
  end

  // Reference model: payload queues per list, output scoreboard, arbitration state.
  logic [W-1:0]    mq [NL][$];
  logic [NL+W-1:0] sb [$];
  int              rr_m;
  bit              prio_pop_m;
  bit              err_m;

  task automatic model_reset();
    for (int l = 0; l < NL; l++) mq[l].delete();
    sb.delete();
    rr_m       = 0;
    prio_pop_m = 1'b0;
    err_m      = 1'b0;
  endtask

  initial begin : monitor
    logic [NL-1:0]   elig, oh;
    logic [NL+W-1:0] e;
    logic [W-1:0]    d;
    bit              exp_valid, c_push, c_pop, w_push, w_pop;
    int              total, gi;
    ll_reset();
    model_reset();
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) ll_reset();
      else ll_apply();
      #2;
      if (!rst_n) begin
        model_reset();
        chk("rst_outputs", {deq_valid, enq_err, enq_ready, ll_push, ll_pop, deq_list, deq_data}, '0);
      end else begin
        exp_valid = (sb.size() != 0);
        chk("deq_valid", 32'(deq_valid), 32'(exp_valid));
        chk("enq_err", 32'(enq_err), 32'(err_m));
        total = 0;
        for (int l = 0; l < NL; l++) begin
          total  += mq[l].size();
          elig[l] = deq_req[l] && (mq[l].size() > 0);
        end
        c_push = enq_valid && (total < NE);
        c_pop  = (elig != '0) && (!exp_valid || deq_ready);
        w_push = c_push && (!c_pop || !prio_pop_m);
        w_pop  = c_pop && !w_push;
        if (c_push && c_pop) prio_pop_m = !prio_pop_m;
        chk("enq_ready", 32'(enq_ready), 32'(w_push));

        if (exp_valid && deq_ready) begin
          e = sb.pop_front();
          chk("deq_data", 32'(deq_data), 32'(e[W-1:0]));
          chk("deq_list", 32'(deq_list), 32'(e[NL+W-1:W]));
        end

        if (w_pop) begin
          gi = -1;
          for (int k = 0; k < NL; k++) begin
            if (gi < 0 && elig[(rr_m + k) % NL]) gi = (rr_m + k) % NL;
          end
          oh     = '0;
          oh[gi] = 1'b1;
          chk("ll_pop", 32'(ll_pop), 32'(oh));
          d = mq[gi].pop_front();
          sb.push_back({oh, d});
          rr_m = (gi + 1) % NL;
        end else begin
          chk("ll_pop_idle", 32'(ll_pop), 0);
        end

        if (w_push && $countones(enq_list) == 1) begin
          chk("ll_push", 32'(ll_push), 32'(enq_list));
          for (int l = 0; l < NL; l++) begin
            if (enq_list[l]) mq[l].push_back(enq_data);
          end
        end else begin
          if (w_push) err_m = 1'b1;
          chk("ll_push_idle", 32'(ll_push), 0);
        end
        pend_push = ll_push;
        pend_pop  = ll_pop;
      end
    end
  end

  task automatic step(input logic ev, input logic [NL-1:0] el, input logic [W-1:0] ed,
                      input logic [NL-1:0] dr, input logic dy);
    enq_valid = ev;
    enq_list  = el;
    enq_data  = ed;
    deq_req   = dr;
    deq_ready = dy;
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) step(1'b0, '0, '0, '0, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin : driver
    logic [NL-1:0] rl;
    rst_n = 1'b0;
    enq_valid = 1'b0; enq_list = '0; enq_data = '0; deq_req = '0; deq_ready = 1'b1;
    @(negedge clk);
    do_reset(2);

    // In-order delivery from one list.
    step(1'b1, 2'b01, 8'hA1, 2'b00, 1'b1);
    step(1'b1, 2'b01, 8'hA2, 2'b00, 1'b1);
    step(1'b1, 2'b01, 8'hA3, 2'b00, 1'b1);
    repeat (5) step(1'b0, 2'b00, 8'h00, 2'b01, 1'b1);

    // Fill to capacity, hold enq against full, then free one slot.
    for (int i = 0; i < 7; i++) step(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, W'($urandom), 2'b00, 1'b1);
    step(1'b1, 2'b10, 8'h5C, 2'b01, 1'b1);
    repeat (3) step(1'b1, 2'b10, 8'h5D, 2'b00, 1'b1);

    // Both lists requesting: grants alternate.
    repeat (7) step(1'b0, 2'b00, 8'h00, 2'b11, 1'b1);

    // Contention from reset: push first, then strict alternation.
    do_reset(1);
    for (int i = 0; i < 10; i++) step(1'b1, 2'b10, W'(8'hC0 + i), 2'b10, 1'b1);
    repeat (4) step(1'b0, 2'b00, 8'h00, 2'b10, 1'b1);

    // Consumer stall with a held element.
    step(1'b1, 2'b01, 8'h31, 2'b00, 1'b1);
    step(1'b1, 2'b01, 8'h32, 2'b00, 1'b1);
    step(1'b0, 2'b00, 8'h00, 2'b01, 1'b1);
    repeat (3) step(1'b0, 2'b00, 8'h00, 2'b01, 1'b0);
    repeat (3) step(1'b0, 2'b00, 8'h00, 2'b01, 1'b1);

    // Malformed lists are consumed and flagged; reset clears flag and output.
    step(1'b1, 2'b11, 8'hEE, 2'b00, 1'b1);
    step(1'b1, 2'b00, 8'hEF, 2'b00, 1'b1);
    step(1'b1, 2'b10, 8'h71, 2'b00, 1'b1);
    step(1'b0, 2'b00, 8'h00, 2'b10, 1'b0);
    step(1'b0, 2'b00, 8'h00, 2'b00, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_enq_err", 32'(enq_err), 0);
    chk("async_rst_deq_valid", 32'(deq_valid), 0);
    step(1'b0, 2'b00, 8'h00, 2'b00, 1'b1);
    step(1'b0, 2'b00, 8'h00, 2'b00, 1'b1);
    rst_n = 1'b1;

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      rl = ($urandom_range(0, 31) == 0) ? NL'($urandom_range(0, 3)) : NL'(1 << $urandom_range(0, NL - 1));
      step(1'b1 & ($urandom_range(0, 2) != 0), rl, W'($urandom), NL'($urandom_range(0, 3)),
           ($urandom_range(0, 3) != 0));
    end

    // Drain the output register.
    repeat (4) step(1'b0, 2'b00, 8'h00, 2'b00, 1'b1);
    #4;
    chk("drain_scoreboard", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
